// File: rtl/word_lane_streamer.sv
// word_lane_streamer
//   Splits an N-bit word into LANES = N/LANE_W lanes and returns them as
//   OUT_W-bit beats, zero- or sign-extended. Single mode returns the one lane
//   chosen by in_sel. Stream mode returns every lane in turn, starting with
//   the least-significant lane. Both sides use valid/ready handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_word/in_mode/in_sel/in_signed are valid
//   in_ready   a word is accepted this cycle when in_valid is also high
//   in_word    word to split (N bits)
//   in_mode    0 = single lane, 1 = stream all lanes
//   in_sel     1-based lane index, single mode only (SW bits)
//   in_signed  1 = sign-extend, 0 = zero-extend
//   out_valid  out_* fields are valid
//   out_ready  downstream accepts the current beat
//   out_data   extended lane value (OUT_W bits)
//   out_index  1-based lane number, 0 on an error beat (SW bits)
//   out_last   final beat of the current word
//   out_err    single mode with in_sel out of range
module word_lane_streamer #(
  parameter int unsigned N      = 32,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned OUT_W  = 32,
  localparam int unsigned SW    = $clog2(N / LANE_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_word,
  input  logic              in_mode,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [SW-1:0]     out_index,
  output logic              out_last,
  output logic              out_err
);

  localparam int unsigned LANES = N / LANE_W;

  // Bits above the lane; set together when a negative lane is sign-extended.
  // Evaluates to zero when OUT_W == LANE_W, so the lane then passes through.
  localparam logic [OUT_W-1:0] UPPER_MASK = ~OUT_W'({LANE_W{1'b1}});

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       word_q, word_d;
  logic               mode_q, mode_d;
  logic               signed_q, signed_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic [SW-1:0]      index_q, index_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  // Lane idx (1-based) of word w; zero for an index with no lane.
  function automatic logic [LANE_W-1:0] pick_lane(input logic [N-1:0] w,
                                                  input logic [SW-1:0] idx);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (idx == SW'(l + 1)) r = w[l*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] extend(input logic [LANE_W-1:0] lane,
                                              input logic              sgn);
    logic [OUT_W-1:0] r;
    r = OUT_W'(lane);
    if (sgn && lane[LANE_W-1]) r = r | UPPER_MASK;
    return r;
  endfunction

  logic accept;
  logic take;
  logic sel_ok;

  // First beat of an incoming word, built straight from the input fields so
  // that it can be registered on the accepting edge.
  logic [OUT_W-1:0] first_data;
  logic [SW-1:0]    first_index;
  logic             first_last;
  logic             first_err;

  // Following beat of a word being streamed, built from the captured word.
  logic [SW-1:0]    next_index;
  logic [OUT_W-1:0] next_data;
  logic             next_last;

  assign out_valid = (state_q == EMIT);
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

  assign take     = out_valid & out_ready;
  // A new word may enter in the same cycle the final beat leaves, which
  // removes the bubble between back-to-back words.
  assign in_ready = !rst && ((state_q == IDLE) || (take && last_q));
  assign accept   = in_valid & in_ready;

  assign sel_ok = (in_sel != '0) && (in_sel <= SW'(LANES));

  always_comb begin
    first_data  = '0;
    first_index = '0;
    first_last  = 1'b1;
    first_err   = 1'b0;
    if (in_mode) begin
      first_index = SW'(1);
      first_data  = extend(pick_lane(in_word, SW'(1)), in_signed);
      first_last  = (LANES == 1);
    end else if (sel_ok) begin
      first_index = in_sel;
      first_data  = extend(pick_lane(in_word, in_sel), in_signed);
    end else begin
      first_err   = 1'b1;
    end
  end

  assign next_index = index_q + SW'(1);
  assign next_data  = extend(pick_lane(word_q, next_index), signed_q);
  assign next_last  = (next_index == SW'(LANES));

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    mode_d   = mode_q;
    signed_d = signed_q;
    data_d   = data_q;
    index_d  = index_q;
    last_d   = last_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = EMIT;
          word_d   = in_word;
          mode_d   = in_mode;
          signed_d = in_signed;
          data_d   = first_data;
          index_d  = first_index;
          last_d   = first_last;
          err_d    = first_err;
        end
      end
      EMIT: begin
        if (take) begin
          if (last_q) begin
            if (accept) begin
              word_d   = in_word;
              mode_d   = in_mode;
              signed_d = in_signed;
              data_d   = first_data;
              index_d  = first_index;
              last_d   = first_last;
              err_d    = first_err;
            end else begin
              state_d = IDLE;
              data_d  = '0;
              index_d = '0;
              last_d  = 1'b0;
              err_d   = 1'b0;
            end
          end else if (mode_q) begin
            data_d  = next_data;
            index_d = next_index;
            last_d  = next_last;
            err_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      mode_q   <= 1'b0;
      signed_q <= 1'b0;
      data_q   <= '0;
      index_q  <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      mode_q   <= mode_d;
      signed_q <= signed_d;
      data_q   <= data_d;
      index_q  <= index_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_word_lane_streamer.sv
// tb_word_lane_streamer
//   Directed bench for word_lane_streamer with default parameters
//   (N=32, LANE_W=8, OUT_W=32, SW=3). Expected beats are queued when a word
//   is issued; a negedge monitor compares every presented beat against the
//   head of the queue and pops it when the beat is taken.
module tb_word_lane_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        in_mode = 1'b0;
  logic [2:0]  in_sel = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        out_err;

  always #5 clk = ~clk;

  word_lane_streamer #(
    .N      (32),
    .LANE_W (8),
    .OUT_W  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_mode   (in_mode),
    .in_sel    (in_sel),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  index;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [2:0] idx,
                             input logic lst, input logic er);
    beat_t b;
    b.data  = d;
    b.index = idx;
    b.last  = lst;
    b.err   = er;
    exp_q.push_back(b);
  endtask

  // Monitor: every valid beat outside reset must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {31'b0, out_valid}, 32'd0);
      end else begin
        check("beat_data",  out_data,           exp_q[0].data);
        check("beat_index", {29'b0, out_index}, {29'b0, exp_q[0].index});
        check("beat_last",  {31'b0, out_last},  {31'b0, exp_q[0].last});
        check("beat_err",   {31'b0, out_err},   {31'b0, exp_q[0].err});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Present one word and hold it until accepted. When immediate is set the
  // word must be taken in its first cycle while the previous beat is shown.
  task automatic send(input logic [31:0] w, input logic m, input logic [2:0] s,
                      input logic sg, input bit immediate);
    int c;
    in_word   = w;
    in_mode   = m;
    in_sel    = s;
    in_signed = sg;
    in_valid  = 1'b1;
    c = 0;
    @(negedge clk);
    if (immediate) check("no_gap_out_valid", {31'b0, out_valid}, 32'd1);
    while (!in_ready && c < 100) begin
      c++;
      @(negedge clk);
    end
    if (c >= 100) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    if (immediate) check("no_bubble_in_ready_wait", c, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = 32'hDEAD_BEEF;
    in_sel   = 3'd7;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] t1_data [4];
    logic [31:0] t2_data [3];
    t1_data = '{32'h0000_00D4, 32'h0000_00C3, 32'h0000_00B2, 32'h0000_00A1};
    t2_data = '{32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h0000_0000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_out_index", {29'b0, out_index}, 32'd0);
    check("rst_out_last",  {31'b0, out_last}, 32'd0);
    check("rst_out_err",   {31'b0, out_err}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single unsigned lanes 1..4, back to back with out_ready high
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      expect_beat(t1_data[i], 3'(i + 1), 1'b1, 1'b0);
      send(32'hA1B2_C3D4, 1'b0, 3'(i + 1), 1'b0, i != 0);
    end
    drain();

    // Single signed lanes 1..3
    for (int unsigned i = 0; i < 3; i++) begin
      expect_beat(t2_data[i], 3'(i + 1), 1'b1, 1'b0);
      send(32'h0000_80FF, 1'b0, 3'(i + 1), 1'b1, i != 0);
    end
    drain();

    // Out-of-range selects
    expect_beat(32'd0, 3'd0, 1'b1, 1'b1);
    send(32'hA1B2_C3D4, 1'b0, 3'd0, 1'b1, 1'b0);
    expect_beat(32'd0, 3'd0, 1'b1, 1'b1);
    send(32'hA1B2_C3D4, 1'b0, 3'd5, 1'b0, 1'b1);
    drain();

    // Stream with out_ready toggling; input fields churn during stalls
    expect_beat(32'h44, 3'd1, 1'b0, 1'b0);
    expect_beat(32'h33, 3'd2, 1'b0, 1'b0);
    expect_beat(32'h22, 3'd3, 1'b0, 1'b0);
    expect_beat(32'h11, 3'd4, 1'b1, 1'b0);
    send(32'h1122_3344, 1'b1, 3'd2, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      in_word   = $urandom;
      in_sel    = 3'($urandom_range(0, 7));
      in_signed = ~in_signed;
      in_mode   = ~in_mode;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Reset after beat 2 of a stream discards the remaining lanes
    expect_beat(32'h88, 3'd1, 1'b0, 1'b0);
    expect_beat(32'h77, 3'd2, 1'b0, 1'b0);
    send(32'h5566_7788, 1'b1, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_during_rst", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_out_data",  out_data, 32'd0);
    check("post_rst_out_index", {29'b0, out_index}, 32'd0);
    check("post_rst_out_last",  {31'b0, out_last}, 32'd0);
    check("post_rst_in_ready",  {31'b0, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_queue", exp_q.size(), 0);

    // Signed stream after reset recovery
    expect_beat(32'h0000_0001, 3'd1, 1'b0, 1'b0);
    expect_beat(32'hFFFF_FFFF, 3'd2, 1'b0, 1'b0);
    expect_beat(32'hFFFF_FF80, 3'd3, 1'b0, 1'b0);
    expect_beat(32'h0000_007F, 3'd4, 1'b1, 1'b0);
    send(32'h7F80_FF01, 1'b1, 3'd6, 1'b1, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
